// File: rtl/mac_gen_pkg.sv
`default_nettype none
// ============================================================================
// mac_gen_pkg : shared types, frame constants and helpers for the MAC TX generator
// Rev 1.0
// ============================================================================
package mac_gen_pkg;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_PAUSE = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOP  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam logic [15:0] MIN_LEN        = 16'd60;
    localparam logic [15:0] MAX_LEN        = 16'd1514;
    localparam logic [47:0] PAUSE_DA       = 48'h0180C2000001;
    localparam logic [15:0] ETH_TYPE_PAUSE = 16'h8808;
    localparam logic [15:0] PAUSE_OPCODE   = 16'h0001;
    localparam int          PAUSE_HDR_BYTES = 18;

    function automatic logic [15:0] eff_len(input mode_e mode, input logic [15:0] len);
        if (mode == MODE_PAUSE) return MIN_LEN;
        if (len < MIN_LEN)      return MIN_LEN;
        if (len > MAX_LEN)      return MAX_LEN;
        return len;
    endfunction

    // Byte n of a PAUSE frame; everything past the quanta field is zero pad.
    function automatic logic [7:0] pause_byte(input logic [15:0] n,
                                              input logic [47:0] sa,
                                              input logic [15:0] quanta);
        logic [8*PAUSE_HDR_BYTES-1:0] hdr;
        hdr = {PAUSE_DA, sa, ETH_TYPE_PAUSE, PAUSE_OPCODE, quanta};
        if (n >= 16'(PAUSE_HDR_BYTES)) return 8'h00;
        return hdr[8*(PAUSE_HDR_BYTES-1-int'(n)) +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_gen_lfsr.sv
`default_nettype none
// ============================================================================
// mac_gen_lfsr : 32-bit Galois LFSR, x^32+x^22+x^2+x+1, sync load and enable
// Rev 1.0
// ============================================================================
module mac_gen_lfsr #(
    parameter logic [31:0] SEED = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        i_load,
    input  logic        i_en,
    output logic [31:0] o_state
);
    localparam logic [31:0] TAP_MASK = 32'h80200003;

    logic [31:0] r_state;

    always_ff @(posedge clk) begin
        if (i_load)
            r_state <= SEED;
        else if (i_en)
            r_state <= r_state[0] ? ((r_state >> 1) ^ TAP_MASK) : (r_state >> 1);
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/mac_tx_gen.sv
`default_nettype none
// ============================================================================
// mac_tx_gen : burst packet generator (incrementing / LFSR / PAUSE) for a MAC TX port
// Rev 1.0
// ============================================================================
module mac_tx_gen
    import mac_gen_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          BE_W      = $clog2(DATA_W/8),
    parameter int          IPG_CYC   = 12,
    parameter logic [47:0] SRC_MAC   = 48'h000000000001,
    parameter logic [31:0] LFSR_SEED = 32'hFFFFFFFF
) (
    input  logic              Clk_user,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    input  logic [1:0]        Mode,
    input  logic [15:0]       Pkt_len,
    input  logic [15:0]       Pkt_cnt,
    input  logic [15:0]       Pause_quanta,
    input  logic              Tx_mac_wa,
    output logic              Tx_mac_wr,
    output logic [DATA_W-1:0] Tx_mac_data,
    output logic [BE_W-1:0]   Tx_mac_BE,
    output logic              Tx_mac_sop,
    output logic              Tx_mac_eop,
    output logic              Busy,
    output logic              Done,
    output logic [15:0]       Sent_cnt
);
    localparam int BPW      = DATA_W / 8;
    localparam int LOG2_BPW = $clog2(BPW);

    state_e      r_state, w_state_nxt;
    mode_e       r_mode, w_mode_in;
    logic [15:0] r_len, r_last_idx, r_widx, r_left, r_gap, r_sent, r_quanta;
    logic        r_cont, r_stop_pend;
    logic        w_start_acc, w_issue, w_last, w_done, w_more, w_lfsr_load, w_lfsr_en;
    logic [15:0] w_len_in, w_base;
    logic [31:0] w_lfsr;
    logic [DATA_W-1:0] w_word, w_lfsr_word;

    assign w_start_acc = (r_state == ST_IDLE) && Start;
    assign w_mode_in   = (Mode == 2'd3) ? MODE_INC : mode_e'(Mode);
    assign w_len_in    = eff_len(w_mode_in, Pkt_len);
    // A Stop arriving on the final gap cycle still ends the burst there.
    assign w_more      = (r_cont || (r_left != 16'd0)) && !r_stop_pend && !Stop;

    always_ff @(posedge Clk_user) begin
        if (Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_last      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: if (Start) w_state_nxt = ST_SOP;
            ST_SOP: begin
                if (Tx_mac_wa) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (Tx_mac_wa) begin
                    w_issue = 1'b1;
                    if (r_widx == r_last_idx) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap == 16'd0) begin
                    if (w_more) begin
                        w_state_nxt = ST_SOP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_lfsr_load = Reset || w_start_acc;
    assign w_lfsr_en   = w_issue && (r_mode == MODE_LFSR);

    mac_gen_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (Clk_user),
        .i_load  (w_lfsr_load),
        .i_en    (w_lfsr_en),
        .o_state (w_lfsr)
    );

    assign w_base      = r_widx << LOG2_BPW;
    assign w_lfsr_word = {(DATA_W/32){w_lfsr}};

    // Per-lane byte mux; bytes beyond the frame length are forced to zero.
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
            logic [15:0] w_n;
            assign w_n = w_base + 16'(gi);
            assign w_word[DATA_W-1-8*gi -: 8] =
                (w_n >= r_len)          ? 8'h00 :
                (r_mode == MODE_LFSR)   ? w_lfsr_word[DATA_W-1-8*gi -: 8] :
                (r_mode == MODE_PAUSE)  ? pause_byte(w_n, SRC_MAC, r_quanta) :
                                          w_n[7:0];
        end
    endgenerate

    always_ff @(posedge Clk_user) begin
        if (Reset) begin
            Tx_mac_wr   <= 1'b0;
            Tx_mac_data <= '0;
            Tx_mac_BE   <= '0;
            Tx_mac_sop  <= 1'b0;
            Tx_mac_eop  <= 1'b0;
            Done        <= 1'b0;
            r_sent      <= 16'd0;
            r_mode      <= MODE_INC;
            r_len       <= MIN_LEN;
            r_last_idx  <= 16'd0;
            r_widx      <= 16'd0;
            r_left      <= 16'd0;
            r_cont      <= 1'b0;
            r_quanta    <= 16'd0;
            r_gap       <= 16'd0;
            r_stop_pend <= 1'b0;
        end else begin
            Tx_mac_wr   <= 1'b0;
            Tx_mac_sop  <= 1'b0;
            Tx_mac_eop  <= 1'b0;
            Tx_mac_data <= '0;
            Tx_mac_BE   <= '0;
            Done        <= w_done;

            if (w_start_acc) begin
                r_mode     <= w_mode_in;
                r_len      <= w_len_in;
                r_last_idx <= (w_len_in - 16'd1) >> LOG2_BPW;
                r_left     <= Pkt_cnt;
                r_cont     <= (Pkt_cnt == 16'd0);
                r_quanta   <= Pause_quanta;
                r_widx     <= 16'd0;
            end

            if (w_issue) begin
                Tx_mac_wr   <= 1'b1;
                Tx_mac_data <= w_word;
                Tx_mac_sop  <= (r_state == ST_SOP);
                Tx_mac_eop  <= w_last;
                Tx_mac_BE   <= w_last ? r_len[BE_W-1:0] : '0;
                r_widx      <= w_last ? 16'd0 : r_widx + 16'd1;
                if (w_last) begin
                    r_sent <= r_sent + 16'd1;
                    if (!r_cont) r_left <= r_left - 16'd1;
                end
            end

            if (w_last)
                r_gap <= 16'(IPG_CYC - 1);
            else if ((r_state == ST_GAP) && (r_gap != 16'd0))
                r_gap <= r_gap - 16'd1;

            if (r_state == ST_IDLE)
                r_stop_pend <= 1'b0;
            else if (Stop)
                r_stop_pend <= 1'b1;
        end
    end

    assign Busy     = (r_state != ST_IDLE);
    assign Sent_cnt = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mac_tx_gen : directed self-checking bench, 32-bit and 64-bit instances
// Rev 1.0
// ============================================================================
module tb_mac_tx_gen;

    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  be;
        logic        sop;
        logic        eop;
    } wrec_t;

    logic Clk_user = 1'b0;
    always #5 Clk_user = ~Clk_user;

    logic        Reset = 1'b1, Start = 1'b0, Stop = 1'b0, Tx_mac_wa = 1'b1;
    logic [1:0]  Mode = 2'd0;
    logic [15:0] Pkt_len = 16'd64, Pkt_cnt = 16'd1, Pause_quanta = 16'd0;

    logic        wr32, sop32, eop32, busy32, done32;
    logic [31:0] data32;
    logic [1:0]  be32;
    logic [15:0] sent32;
    logic        wr64, sop64, eop64, busy64, done64;
    logic [63:0] data64;
    logic [2:0]  be64;
    logic [15:0] sent64;

    mac_tx_gen #(.DATA_W(32)) u_dut32 (
        .Clk_user(Clk_user), .Reset(Reset), .Start(Start), .Stop(Stop), .Mode(Mode),
        .Pkt_len(Pkt_len), .Pkt_cnt(Pkt_cnt), .Pause_quanta(Pause_quanta), .Tx_mac_wa(Tx_mac_wa),
        .Tx_mac_wr(wr32), .Tx_mac_data(data32), .Tx_mac_BE(be32), .Tx_mac_sop(sop32),
        .Tx_mac_eop(eop32), .Busy(busy32), .Done(done32), .Sent_cnt(sent32)
    );

    mac_tx_gen #(.DATA_W(64)) u_dut64 (
        .Clk_user(Clk_user), .Reset(Reset), .Start(Start), .Stop(Stop), .Mode(Mode),
        .Pkt_len(Pkt_len), .Pkt_cnt(Pkt_cnt), .Pause_quanta(Pause_quanta), .Tx_mac_wa(Tx_mac_wa),
        .Tx_mac_wr(wr64), .Tx_mac_data(data64), .Tx_mac_BE(be64), .Tx_mac_sop(sop64),
        .Tx_mac_eop(eop64), .Busy(busy64), .Done(done64), .Sent_cnt(sent64)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    wrec_t q32[$];
    wrec_t q64[$];
    logic wa_s = 1'b1;
    int bp_viol = 0, eop_cyc32 = 0, done_cyc32 = 0, done_cnt32 = 0, done_cnt64 = 0;

    always @(posedge Clk_user) begin
        cyc  <= cyc + 1;
        wa_s <= Tx_mac_wa;
    end

    always @(negedge Clk_user) begin
        if (wr32) begin
            q32.push_back({64'(data32), 3'(be32), sop32, eop32});
            if (eop32) eop_cyc32 = cyc;
            if (!wa_s) bp_viol++;
        end
        if (wr64) q64.push_back({data64, be64, sop64, eop64});
        if (done32) begin
            done_cnt32++;
            done_cyc32 = cyc;
        end
        if (done64) done_cnt64++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected incrementing-pattern word; bytes at or past len read as zero.
    function automatic logic [63:0] inc_word(input int idx, input int bpw, input int len);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < bpw; j++) begin
            int n;
            n = idx * bpw + j;
            w = (w << 8) | ((n < len) ? 64'(n & 255) : 64'd0);
        end
        return w;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
    endfunction

    task automatic tick();
        @(negedge Clk_user);
        #1;
    endtask

    task automatic clear_mon();
        q32.delete();
        q64.delete();
        bp_viol    = 0;
        done_cnt32 = 0;
        done_cnt64 = 0;
        eop_cyc32  = 0;
        done_cyc32 = 0;
    endtask

    task automatic start_burst(input logic [1:0] m, input logic [15:0] len,
                               input logic [15:0] cnt, input logic [15:0] quanta);
        clear_mon();
        Mode = m; Pkt_len = len; Pkt_cnt = cnt; Pause_quanta = quanta;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(input bit sel64, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel64 ? done_cnt64 : done_cnt32) != 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({wr32, sop32, eop32, busy32, done32} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl32: got %b want 00000", {wr32, sop32, eop32, busy32, done32});
        end
        n_vec++;
        if (data32 !== 32'd0 || be32 !== 2'd0) begin
            n_err++; $display("FAIL reset_data32: got %h/%h want 0/0", data32, be32);
        end
        n_vec++;
        if (sent32 !== 16'd0) begin
            n_err++; $display("FAIL reset_sent32: got %0d want 0", sent32);
        end
        n_vec++;
        if ({wr64, busy64, done64} !== 3'b0 || data64 !== 64'd0) begin
            n_err++; $display("FAIL reset_64: got %b %h want 000 0", {wr64, busy64, done64}, data64);
        end
        Reset = 1'b0;
        tick();
        n_vec++;
        if (busy32 !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset: busy %b want 0", busy32);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int nsop, neop;
        start_burst(2'd0, 16'd64, 16'd1, 16'd0);
        n_vec++;
        if (busy32 !== 1'b1) begin
            n_err++; $display("FAIL busy_start: got %b want 1", busy32);
        end
        wait_done(1'b0, 500, ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL basic_timeout: done %0d want 1", done_cnt32);
        end
        n_vec++;
        if (q32.size() != 16) begin
            n_err++; $display("FAIL basic_words: got %0d want 16", q32.size());
        end
        nsop = 0; neop = 0;
        for (int i = 0; i < q32.size(); i++) begin
            n_vec++;
            if (q32[i].d[31:0] !== inc_word(i, 4, 64)) begin
                n_err++; $display("FAIL basic_data[%0d]: got %h want %h", i, q32[i].d[31:0], inc_word(i, 4, 64));
            end
            nsop += int'(q32[i].sop);
            neop += int'(q32[i].eop);
        end
        n_vec++;
        if (q32.size() > 0 && (q32[0].sop !== 1'b1 || q32[0].d[31:0] !== 32'h00010203)) begin
            n_err++; $display("FAIL basic_first: sop %b data %h want 1 00010203", q32[0].sop, q32[0].d[31:0]);
        end
        n_vec++;
        if (nsop != 1 || neop != 1) begin
            n_err++; $display("FAIL basic_markers: sop %0d eop %0d want 1 1", nsop, neop);
        end
        n_vec++;
        if (q32.size() > 0 && (q32[q32.size()-1].eop !== 1'b1 || q32[q32.size()-1].be !== 3'd0)) begin
            n_err++; $display("FAIL basic_eop: eop %b be %0d want 1 0", q32[q32.size()-1].eop, q32[q32.size()-1].be);
        end
        n_vec++;
        if (done_cyc32 - eop_cyc32 != 12) begin
            n_err++; $display("FAIL basic_gap: got %0d want 12", done_cyc32 - eop_cyc32);
        end
        n_vec++;
        if (done32 !== 1'b1 || busy32 !== 1'b0) begin
            n_err++; $display("FAIL basic_done_busy: done %b busy %b want 1 0", done32, busy32);
        end
        tick();
        n_vec++;
        if (done32 !== 1'b0 || sent32 !== 16'd1) begin
            n_err++; $display("FAIL basic_pulse_sent: done %b sent %0d want 0 1", done32, sent32);
        end
    endtask

    task automatic test_len_edges();
        bit ok;
        start_burst(2'd0, 16'd61, 16'd1, 16'd0);
        wait_done(1'b0, 500, ok);
        n_vec++;
        if (!ok || q32.size() != 16) begin
            n_err++; $display("FAIL len61_words: got %0d ok %b want 16 1", q32.size(), ok);
        end
        n_vec++;
        if (q32.size() > 0 && (q32[q32.size()-1].d[31:0] !== 32'h3C000000 || q32[q32.size()-1].be !== 3'd1)) begin
            n_err++; $display("FAIL len61_eop: got %h be %0d want 3c000000 be 1", q32[q32.size()-1].d[31:0], q32[q32.size()-1].be);
        end
        tick();
        start_burst(2'd0, 16'd20, 16'd1, 16'd0);
        wait_done(1'b0, 500, ok);
        n_vec++;
        if (!ok || q32.size() != 15) begin
            n_err++; $display("FAIL len20_words: got %0d ok %b want 15 1", q32.size(), ok);
        end
        n_vec++;
        if (q32.size() > 0 && (q32[q32.size()-1].d[31:0] !== 32'h38393A3B || q32[q32.size()-1].be !== 3'd0)) begin
            n_err++; $display("FAIL len20_eop: got %h be %0d want 38393a3b be 0", q32[q32.size()-1].d[31:0], q32[q32.size()-1].be);
        end
        tick();
        start_burst(2'd0, 16'd2000, 16'd1, 16'd0);
        wait_done(1'b0, 1000, ok);
        n_vec++;
        if (!ok || q32.size() != 379 || (q32.size() > 0 && q32[q32.size()-1].be !== 3'd2)) begin
            n_err++; $display("FAIL len_max: got %0d words ok %b want 379 be 2", q32.size(), ok);
        end
        tick();
    endtask

    task automatic test_pause();
        bit ok;
        logic [31:0] hdr [5];
        logic [31:0] exp_w;
        hdr[0] = 32'h0180C200; hdr[1] = 32'h00010000; hdr[2] = 32'h00000001;
        hdr[3] = 32'h88080001; hdr[4] = 32'h000A0000;
        start_burst(2'd2, 16'd1000, 16'd1, 16'h000A);
        wait_done(1'b0, 500, ok);
        n_vec++;
        if (!ok || q32.size() != 15) begin
            n_err++; $display("FAIL pause_words: got %0d ok %b want 15 1", q32.size(), ok);
        end
        for (int i = 0; i < q32.size(); i++) begin
            exp_w = (i < 5) ? hdr[i] : 32'd0;
            n_vec++;
            if (q32[i].d[31:0] !== exp_w) begin
                n_err++; $display("FAIL pause_data[%0d]: got %h want %h", i, q32[i].d[31:0], exp_w);
            end
        end
        tick();
    endtask

    task automatic test_lfsr();
        bit ok;
        logic [31:0] x;
        start_burst(2'd1, 16'd64, 16'd1, 16'd0);
        wait_done(1'b0, 500, ok);
        n_vec++;
        if (!ok || q32.size() != 16) begin
            n_err++; $display("FAIL lfsr_words: got %0d ok %b want 16 1", q32.size(), ok);
        end
        x = 32'hFFFFFFFF;
        for (int i = 0; i < q32.size(); i++) begin
            n_vec++;
            if (q32[i].d[31:0] !== x) begin
                n_err++; $display("FAIL lfsr_data[%0d]: got %h want %h", i, q32[i].d[31:0], x);
            end
            x = lfsr_next(x);
        end
        tick();
        start_burst(2'd3, 16'd60, 16'd1, 16'd0);
        wait_done(1'b0, 500, ok);
        n_vec++;
        if (!ok || q32.size() != 15 || q32[0].d[31:0] !== 32'h00010203) begin
            n_err++; $display("FAIL mode3: got %0d words first %h want 15 00010203", q32.size(), q32.size() > 0 ? q32[0].d[31:0] : 32'hx);
        end
        tick();
    endtask

    task automatic test_backpressure();
        start_burst(2'd0, 16'd64, 16'd1, 16'd0);
        for (int c = 0; c < 600 && done_cnt32 == 0; c++) begin
            if (c % 3 == 2) Tx_mac_wa = ~Tx_mac_wa;
            tick();
        end
        Tx_mac_wa = 1'b1;
        n_vec++;
        if (done_cnt32 == 0 || q32.size() != 16) begin
            n_err++; $display("FAIL bp_words: got %0d done %0d want 16 1", q32.size(), done_cnt32);
        end
        n_vec++;
        if (bp_viol != 0) begin
            n_err++; $display("FAIL bp_wr_while_low: got %0d want 0", bp_viol);
        end
        for (int i = 0; i < q32.size(); i++) begin
            n_vec++;
            if (q32[i].d[31:0] !== inc_word(i, 4, 64)) begin
                n_err++; $display("FAIL bp_data[%0d]: got %h want %h", i, q32[i].d[31:0], inc_word(i, 4, 64));
            end
        end
        tick();
    endtask

    task automatic test_stop_cont();
        bit stopped, ok;
        Reset = 1'b1; tick(); Reset = 1'b0; tick();
        start_burst(2'd0, 16'd60, 16'd0, 16'd0);
        Mode = 2'd1; Pkt_len = 16'd100; Pkt_cnt = 16'd1;
        stopped = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (done_cnt32 != 0) begin
                ok = 1'b1;
                break;
            end
            if (!stopped && q32.size() >= 35) begin
                Stop = 1'b1; tick(); Stop = 1'b0;
                stopped = 1'b1;
            end else begin
                tick();
            end
        end
        n_vec++;
        if (!ok || !stopped || q32.size() != 45) begin
            n_err++; $display("FAIL stop_words: got %0d ok %b want 45 1", q32.size(), ok);
        end
        for (int i = 0; i < q32.size(); i++) begin
            n_vec++;
            if (q32[i].d[31:0] !== inc_word(i % 15, 4, 60)) begin
                n_err++; $display("FAIL stop_data[%0d]: got %h want %h", i, q32[i].d[31:0], inc_word(i % 15, 4, 60));
            end
        end
        n_vec++;
        if (sent32 !== 16'd3 || busy32 !== 1'b0) begin
            n_err++; $display("FAIL stop_sent: got %0d busy %b want 3 0", sent32, busy32);
        end
        tick();
        Stop = 1'b1; tick(); Stop = 1'b0;
        n_vec++;
        if (busy32 !== 1'b0) begin
            n_err++; $display("FAIL stop_in_idle: busy %b want 0", busy32);
        end
        Stop = 1'b1;
        start_burst(2'd0, 16'd60, 16'd1, 16'd0);
        Stop = 1'b0;
        n_vec++;
        if (busy32 !== 1'b1) begin
            n_err++; $display("FAIL start_wins: busy %b want 1", busy32);
        end
        wait_done(1'b0, 500, ok);
        n_vec++;
        if (!ok || q32.size() != 15 || sent32 !== 16'd4) begin
            n_err++; $display("FAIL start_wins_pkt: got %0d words sent %0d want 15 4", q32.size(), sent32);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        start_burst(2'd0, 16'd64, 16'd1, 16'd0);
        for (int c = 0; c < 200 && q32.size() < 7; c++) tick();
        n_vec++;
        if (busy32 !== 1'b1 || q32.size() != 7) begin
            n_err++; $display("FAIL mid_setup: busy %b words %0d want 1 7", busy32, q32.size());
        end
        Reset = 1'b1;
        tick();
        n_vec++;
        if ({wr32, sop32, eop32, busy32, done32} !== 5'b0 || data32 !== 32'd0 || be32 !== 2'd0) begin
            n_err++; $display("FAIL mid_reset_out: ctrl %b data %h be %0d want 0", {wr32, sop32, eop32, busy32, done32}, data32, be32);
        end
        n_vec++;
        if (sent32 !== 16'd0) begin
            n_err++; $display("FAIL mid_reset_sent: got %0d want 0", sent32);
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_dw64();
        bit ok;
        start_burst(2'd0, 16'd61, 16'd1, 16'd0);
        wait_done(1'b1, 500, ok);
        n_vec++;
        if (!ok || q64.size() != 8) begin
            n_err++; $display("FAIL dw64_words: got %0d ok %b want 8 1", q64.size(), ok);
        end
        n_vec++;
        if (q64.size() > 0 && (q64[0].d !== 64'h0001020304050607 || q64[0].sop !== 1'b1)) begin
            n_err++; $display("FAIL dw64_first: got %h sop %b want 0001020304050607 1", q64[0].d, q64[0].sop);
        end
        n_vec++;
        if (q64.size() > 0 && (q64[q64.size()-1].d !== 64'h38393A3B3C000000 ||
                               q64[q64.size()-1].be !== 3'd5 || q64[q64.size()-1].eop !== 1'b1)) begin
            n_err++; $display("FAIL dw64_eop: got %h be %0d want 38393a3b3c000000 be 5", q64[q64.size()-1].d, q64[q64.size()-1].be);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_len_edges();
        test_pause();
        test_lfsr();
        test_backpressure();
        test_stop_cont();
        test_reset_mid();
        test_dw64();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
